// File: rtl/alu_result_uart_tx.sv
// UART transmitter for a 3-byte ALU result packet {0xA5, result, {4'h0, flags}}, 8N1 framing.
// Define ALU_UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module alu_result_uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [7:0] result,
  input  logic [3:0] flags,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef ALU_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] baud_reg, baud_next;
  logic [2:0]       bit_reg, bit_next;
  logic [1:0]       byte_reg, byte_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       result_reg, result_next;
  logic [3:0]       flags_reg, flags_next;
  logic             pending_reg, pending_next;
  logic             tx_reg, tx_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
`ifdef ALU_UART_TX_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  logic       baud_end;
  logic [7:0] next_byte;

  assign baud_end  = (baud_reg == BAUD_LAST);
  assign next_byte = (byte_reg == 2'd0) ? result_reg : {4'h0, flags_reg};

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_next     = bit_reg;
    byte_next    = byte_reg;
    shift_next   = shift_reg;
    result_next  = result_reg;
    flags_next   = flags_reg;
    pending_next = pending_reg;
    tx_next      = tx_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
`ifdef ALU_UART_TX_PARITY_EN
    parity_next  = parity_reg;
`endif

    case (state_reg)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (send) begin
          result_next  = result;
          flags_next   = flags;
          byte_next    = 2'd0;
          bit_next     = 3'd0;
          baud_next    = '0;
          shift_next   = HEADER;
          pending_next = 1'b1;
          busy_next    = 1'b1;
          state_next   = START;
`ifdef ALU_UART_TX_PARITY_EN
          parity_next  = ^HEADER;
`endif
        end
      end

      START: begin
        // The first start bit of a packet is delayed one cycle after accept.
        if (pending_reg) begin
          pending_next = 1'b0;
          tx_next      = 1'b0;
        end else if (baud_end) begin
          baud_next  = '0;
          tx_next    = shift_reg[0];
          state_next = DATA;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end

      DATA: begin
        if (baud_end) begin
          baud_next = '0;
          if (bit_reg == 3'd7) begin
            bit_next = 3'd0;
`ifdef ALU_UART_TX_PARITY_EN
            tx_next    = parity_reg;
            state_next = PARITY;
`else
            tx_next    = 1'b1;
            state_next = STOP;
`endif
          end else begin
            bit_next   = bit_reg + 1'b1;
            shift_next = {1'b0, shift_reg[7:1]};
            tx_next    = shift_reg[1];
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end

`ifdef ALU_UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          baud_next  = '0;
          tx_next    = 1'b1;
          state_next = STOP;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
`endif

      STOP: begin
        if (baud_end) begin
          baud_next = '0;
          if (byte_reg == 2'd2) begin
            tx_next    = 1'b1;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            // Next byte starts immediately, no idle gap on the line.
            byte_next  = byte_reg + 1'b1;
            shift_next = next_byte;
            tx_next    = 1'b0;
            state_next = START;
`ifdef ALU_UART_TX_PARITY_EN
            parity_next = ^next_byte;
`endif
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end

      default: begin
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_reg     <= 3'd0;
      byte_reg    <= 2'd0;
      shift_reg   <= 8'h00;
      result_reg  <= 8'h00;
      flags_reg   <= 4'h0;
      pending_reg <= 1'b0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
`ifdef ALU_UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_reg     <= bit_next;
      byte_reg    <= byte_next;
      shift_reg   <= shift_next;
      result_reg  <= result_next;
      flags_reg   <= flags_next;
      pending_reg <= pending_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
`ifdef ALU_UART_TX_PARITY_EN
      parity_reg  <= parity_next;
`endif
    end
  end

  assign tx   = tx_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule
